// File: rtl/sign_ext_pkg.sv
// Shared types and constants for the stream sign extender.
// Widths for the in_bits field are derived here from the source width.
package sign_ext_pkg;

    localparam int unsigned STATS_W      = 32;
    localparam int unsigned IN_WIDTH_DEF = 16;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while (r < 32 && (64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

    // in_bits must encode 0..IN_WIDTH, hence IN_WIDTH+1 distinct values
    function automatic int unsigned bits_w(input int unsigned in_width);
        return clog2(in_width + 1);
    endfunction

    localparam int unsigned BITS_W = bits_w(IN_WIDTH_DEF);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

endpackage

// File: rtl/stream_sign_extender_pipe_skid_stage.sv
// Two-entry ready/valid register stage with registered upstream ready.
// Head entry drives the output; tail absorbs a word while downstream stalls.
module pipe_skid_stage
    import sign_ext_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    stage_state_e     state;
    stage_state_e     state_next;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] head_next;
    logic [WIDTH-1:0] tail;
    logic [WIDTH-1:0] tail_next;
    logic             up;
    logic             dn;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            head      <= '0;
            tail      <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            head      <= head_next;
            tail      <= tail_next;
            in_ready  <= (state_next != ST_TWO);
            out_valid <= (state_next != ST_EMPTY);
        end
    end

    always_comb begin
        up         = in_valid & in_ready;
        dn         = out_valid & out_ready;
        state_next = state;
        head_next  = head;
        tail_next  = tail;
        case (state)
            ST_EMPTY: begin
                if (up) begin
                    head_next  = in_data;
                    state_next = ST_ONE;
                end
            end
            ST_ONE: begin
                if (up && dn) begin
                    head_next = in_data;
                end else if (up) begin
                    tail_next  = in_data;
                    state_next = ST_TWO;
                end else if (dn) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (dn) begin
                    head_next  = tail;
                    state_next = ST_ONE;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    assign out_data = head;

endmodule

// File: rtl/stream_sign_extender.sv
// Two-stage ready/valid sign/zero extender with runtime source width.
// Optional negative-word counter enabled by defining SIGN_EXT_STATS_EN.
module stream_sign_extender
    import sign_ext_pkg::*;
#(
    parameter  int unsigned IN_WIDTH  = 16,
    parameter  int unsigned OUT_WIDTH = 32,
    localparam int unsigned IN_BITS_W = bits_w(IN_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [IN_BITS_W-1:0] in_bits,
    input  logic                 in_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_err
`ifdef SIGN_EXT_STATS_EN
    ,
    output logic [STATS_W-1:0]   neg_count
`endif
);

    if (IN_WIDTH < 1) begin : g_bad_in_width
        $error("stream_sign_extender: IN_WIDTH must be >= 1");
    end
    if (OUT_WIDTH < IN_WIDTH) begin : g_bad_out_width
        $error("stream_sign_extender: OUT_WIDTH must be >= IN_WIDTH");
    end

    typedef struct packed {
        logic [IN_WIDTH-1:0]  data;
        logic [IN_BITS_W-1:0] n;
        logic                 err;
        logic                 ext;
    } s1_payload_t;

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic                 err;
`ifdef SIGN_EXT_STATS_EN
        logic                 ext;
`endif
    } s2_payload_t;

    s1_payload_t s1_in;
    s1_payload_t s1_out;
    s2_payload_t s2_in;
    s2_payload_t s2_out;
    logic        s1_valid;
    logic        s2_ready;

    // Clamp illegal widths, mask ignored high bits, pick the extension bit
    always_comb begin
        s1_in     = '0;
        s1_in.err = (in_bits == '0) || (int'(in_bits) > int'(IN_WIDTH));
        s1_in.n   = s1_in.err ? IN_BITS_W'(IN_WIDTH) : in_bits;
        for (int i = 0; i < int'(IN_WIDTH); i++) begin
            if (i < int'(s1_in.n)) begin
                s1_in.data[i] = in_data[i];
            end
            if (i == int'(s1_in.n) - 1) begin
                s1_in.ext = in_signed & in_data[i];
            end
        end
    end

    pipe_skid_stage #(.WIDTH($bits(s1_payload_t))) u_stage1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_out)
    );

    // Fill every bit at or above n with the extension bit
    always_comb begin
        s2_in      = '0;
        s2_in.data = OUT_WIDTH'(s1_out.data);
        for (int i = 0; i < int'(OUT_WIDTH); i++) begin
            if (i >= int'(s1_out.n)) begin
                s2_in.data[i] = s1_out.ext;
            end
        end
        s2_in.err = s1_out.err;
`ifdef SIGN_EXT_STATS_EN
        s2_in.ext = s1_out.ext;
`endif
    end

    pipe_skid_stage #(.WIDTH($bits(s2_payload_t))) u_stage2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_out)
    );

    assign out_data = s2_out.data;
    assign out_err  = s2_out.err;

`ifdef SIGN_EXT_STATS_EN
    // Saturating count of delivered words whose extension bit was 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_count <= '0;
        end else if (out_valid && out_ready && s2_out.ext && (neg_count != '1)) begin
            neg_count <= neg_count + STATS_W'(1);
        end
    end
`endif

endmodule
